// File: rtl/lsu_mem_port.sv
// Load/store port: one request at a time onto a variable-latency byte-enabled data bus.
// Latency: 3 cycles minimum (accept, bus+ack, response); response held until resp_ready, req_ready low while busy.
module lsu_mem_port #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int          CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit          TO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_write;
    logic              r_byte;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;

    logic              w_idle;
    logic              w_in_bus;
    logic              w_accept;
    logic              w_misalign;
    logic              w_bus_ack;
    logic              w_expire;
    logic [7:0]        w_lane_byte;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_ack_data;

    assign w_idle     = (r_state == S_IDLE);
    assign w_in_bus   = (r_state == S_BUS);
    assign w_accept   = req_valid & w_idle;
    assign w_misalign = ~req_byte & (req_addr[1:0] != 2'b00);
    assign w_bus_ack  = w_in_bus & mem_ack;
    // An ack in the expiry cycle takes priority, so expiry requires no ack.
    assign w_expire   = TO_EN & w_in_bus & ~mem_ack & (r_cnt == TO_LAST);

    assign w_lane_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_load_data = r_byte ? {{(DATA_W-8){1'b0}}, w_lane_byte} : mem_rdata;
    assign w_ack_data  = r_write ? '0 : w_load_data;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_misalign ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                if (mem_ack || w_expire) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_byte      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_write <= req_write;
                r_byte  <= req_byte;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= '0;
                if (w_misalign) begin
                    r_resp_data <= '0;
                    r_resp_err  <= 1'b1;
                end
            end else if (w_in_bus) begin
                // Saturate so a disabled timeout never wraps the counter.
                if (!mem_ack && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_bus_ack) begin
                    r_resp_data <= w_ack_data;
                    r_resp_err  <= 1'b0;
                end else if (w_expire) begin
                    r_resp_data <= '0;
                    r_resp_err  <= 1'b1;
                end
            end
        end
    end

    assign req_ready  = w_idle;
    assign resp_valid = (r_state == S_RESP);
    assign resp_data  = resp_valid ? r_resp_data : '0;
    assign resp_err   = resp_valid & r_resp_err;

    // Bus outputs are only driven while the request is outstanding.
    assign mem_req   = w_in_bus;
    assign mem_we    = w_in_bus & r_write;
    assign mem_addr  = w_in_bus ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be    = !w_in_bus ? 4'b0000 :
                       r_byte    ? (4'b0001 << r_addr[1:0]) : 4'b1111;
    assign mem_wdata = !w_in_bus ? '0 :
                       r_byte    ? {(DATA_W/8){r_wdata[7:0]}} : r_wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port with TIMEOUT = 4: directed plan followed by random transactions.
// Expected bus fields and responses come from arithmetic on each request, not from the DUT.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    localparam int TO = 4;

    lsu_mem_port #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ack_dly: number of mem_req cycles before the ack cycle; >= TO means no ack arrives.
    task automatic do_txn(input bit wr, input bit by, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_dly,
                          input logic [31:0] rdata, input int hold);
        bit          mis;
        bit          tmo;
        int          n;
        int          exp_n;
        int          lane;
        logic [31:0] exp_data;
        logic [31:0] exp_wd;
        logic [31:0] exp_be;
        mis    = !by && (addr % 4 != 0);
        lane   = int'(addr % 4);
        exp_be = by ? (32'd1 << lane) : 32'hF;
        exp_wd = by ? (wdata & 32'hFF) * 32'h0101_0101 : wdata;
        tmo    = 1'b0;
        check("idle_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_byte  = by;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (mis) begin
            check("misalign_no_mem_req", mem_req, 0);
        end else begin
            check("mem_req_rise", mem_req, 1);
            exp_n = (ack_dly < TO) ? ack_dly + 1 : TO;
            n = 0;
            while (mem_req === 1'b1 && n < 20) begin
                check("bus_we", mem_we, wr);
                check("bus_addr", mem_addr, addr & ~32'd3);
                check("bus_be", mem_be, exp_be);
                check("bus_wdata", mem_wdata, exp_wd);
                check("bus_req_ready", req_ready, 0);
                if (n == ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                step();
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                n++;
            end
            check("bus_cycles", n, exp_n);
            tmo = (ack_dly >= TO);
        end
        exp_data = (mis || tmo || wr) ? 32'd0 :
                   by ? ((rdata >> (8 * lane)) & 32'hFF) : rdata;
        for (int h = 0; h < hold; h++) begin
            check("hold_resp_valid", resp_valid, 1);
            check("hold_resp_data", resp_data, exp_data);
            check("hold_resp_err", resp_err, mis || tmo);
            check("hold_req_ready", req_ready, 0);
            check("hold_mem_req", mem_req, 0);
            if (tmo && h == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom | 32'h1;
            end
            step();
            mem_ack = 1'b0;
        end
        check("resp_valid", resp_valid, 1);
        check("resp_data", resp_data, exp_data);
        check("resp_err", resp_err, mis || tmo);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("post_resp_valid", resp_valid, 0);
        check("post_req_ready", req_ready, 1);
    endtask

    initial begin
        bit          wr;
        bit          by;
        logic [31:0] addr;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_byte   = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;

        @(negedge clk);
        step();
        step();
        check("rst_mem_req", mem_req, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        step();
        check("rst_req_ready", req_ready, 1);

        // Word load, byte load, byte store, misaligned word store.
        do_txn(1'b0, 1'b0, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 1'b1, 32'h103, 32'h0, 1, 32'hA1B2_C3D4, 0);
        do_txn(1'b1, 1'b1, 32'h201, 32'h1234_5677, 0, 32'hFFFF_FFFF, 1);
        do_txn(1'b1, 1'b0, 32'h102, 32'hCAFE_F00D, 0, 32'h0, 1);

        // Timeout with a late ack in RESP, a stray ack in IDLE, then a clean load.
        do_txn(1'b0, 1'b0, 32'h400, 32'h0, 99, 32'h5555_5555, 2);
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_0001;
        step();
        mem_ack = 1'b0;
        check("stray_ack_resp_valid", resp_valid, 0);
        check("stray_ack_mem_req", mem_req, 0);
        check("stray_ack_req_ready", req_ready, 1);
        do_txn(1'b0, 1'b0, 32'h404, 32'h0, 0, 32'h0BAD_F00D, 0);

        // Ack in the expiry cycle wins; backpressure for 5 cycles.
        do_txn(1'b0, 1'b1, 32'h502, 32'h0, TO - 1, 32'h1122_3344, 5);

        // Reset while BUS.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'h300;
        step();
        req_valid = 1'b0;
        check("rstbus_mem_req_before", mem_req, 1);
        step();
        rst_n = 1'b0;
        step();
        check("rstbus_mem_req", mem_req, 0);
        check("rstbus_resp_valid", resp_valid, 0);
        rst_n = 1'b1;
        step();
        check("rstbus_req_ready", req_ready, 1);
        check("rstbus_mem_req_after", mem_req, 0);
        do_txn(1'b1, 1'b0, 32'h308, 32'h89AB_CDEF, 1, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            by   = 1'($urandom_range(0, 1));
            addr = $urandom;
            if (!by && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            do_txn(wr, by, addr, $urandom, $urandom_range(0, 5), $urandom,
                   $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit that acts on the memory controls the decoder produces (memEn, memRW, word/byte from LDW/LDB/STW/STB).
- Takes one load/store request from execute and runs it on a variable-latency data-memory bus with byte enables.
- Returns load data or store completion to writeback through a valid/ready handshake.
- Sits between the execute stage (ALU address) and data memory.

Parameters:
- DATA_W, 32, data width in bits; must be 32 (4 byte lanes).
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before failing with an error; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  execute presents a memory operation (memEn).
- req_ready  out  1  unit can accept a request.
- req_write  in  1  0 = load, 1 = store (memRW).
- req_byte  in  1  1 = byte op (LDB/STB), 0 = word op (LDW/STW).
- req_addr  in  ADDR_W  byte address from ALU.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  writeback accepts the response.
- resp_data  out  DATA_W  load result; 0 for stores and errors.
- resp_err  out  1  misaligned access or timeout.
- mem_req  out  1  bus request; held high until ack or timeout.
- mem_we  out  1  bus write enable.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_W  bus write data.
- mem_ack  in  1  bus completion, one-cycle pulse.
- mem_rdata  in  DATA_W  read data, valid when mem_ack = 1.

Behaviour:
- FSM states IDLE, BUS, RESP. Reset state IDLE.
- Reset values: all outputs 0, except req_ready = 1 once in IDLE. Timeout counter = 0.
- req_ready = 1 only in IDLE.
- Accept (req_valid & req_ready): latch write, byte, addr and wdata.
- Misaligned check: a word op with addr[1:0] != 0 goes IDLE -> RESP with resp_err = 1 and resp_data = 0. No bus cycle is issued.
- Otherwise IDLE -> BUS. mem_req rises on the cycle after accept.
- In BUS, mem_we, mem_addr, mem_be and mem_wdata are stable:
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Word op: mem_be = 4'b1111, mem_wdata = wdata.
  - Byte op: mem_be = 4'b0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
- mem_ack in BUS: drop mem_req on the next cycle and go BUS -> RESP with resp_err = 0.
  - Word load: resp_data = mem_rdata.
  - Byte load: resp_data = zero-extended byte lane addr[1:0] of mem_rdata.
  - Store: resp_data = 0.
- Timeout counter: cleared on entry to BUS; increments each BUS cycle without ack.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT: BUS -> RESP with resp_err = 1, resp_data = 0, mem_req dropped.
  - Ack arriving in the same cycle as expiry wins: normal response, no error.
- mem_ack outside BUS is ignored. A late ack after a timeout must not corrupt the next transaction.
- RESP: resp_valid = 1 with resp_data and resp_err held stable until resp_ready. On resp_valid & resp_ready, go RESP -> IDLE.
- Minimum occupancy is 3 cycles per transaction (accept, bus+ack, handshake). No overlap between transactions.
- Reset asserted in any state: the next edge returns to IDLE with all outputs cleared. An in-flight mem_req is abandoned.
- Widths: the byte-lane select uses the latched addr[1:0]. The counter is wide enough for TIMEOUT with no wrap.

Test Plan:
- Word load: addr = 0x100, mem_ack 2 cycles after mem_req, mem_rdata = 0xDEADBEEF -> mem_addr = 0x100, mem_be = 1111, mem_we = 0; resp_data = 0xDEADBEEF, resp_err = 0.
- Byte load: addr = 0x103, mem_rdata = 0xA1B2C3D4 -> mem_addr = 0x100, mem_be = 1000; resp_data = 0x000000A1.
- Byte store: addr = 0x201, wdata = 0x12345677 -> mem_we = 1, mem_be = 0010, mem_wdata = 0x77777777; resp_data = 0, resp_err = 0.
- Misaligned word store to 0x102 -> mem_req never asserted; resp_valid with resp_err = 1 one cycle after accept.
- Timeout: TIMEOUT = 4, no ack -> mem_req high for exactly 4 cycles, then resp_err = 1. A later stray mem_ack in IDLE is ignored, and the next load completes correctly.
- Backpressure and reset:
  - Hold resp_ready = 0 for 5 cycles -> resp_valid, resp_data and resp_err stable, req_ready = 0.
  - Assert rst_n = 0 during BUS -> next cycle mem_req = 0, resp_valid = 0, req_ready = 1 after release.
